// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the theremin frequency measurement scheduler.
//   - state_e : scheduler FSM states
//   - ch_e    : measurement channel (pitch / volume)
//   - rr_pick : round-robin grant given the priority pointer and request levels
package freq_meas_pkg;

  localparam int unsigned GATE_CYCLES_DEF   = 50000;  // 1 ms at 50 MHz
  localparam int unsigned SETTLE_CYCLES_DEF = 2;
  localparam int unsigned CNT_W_DEF         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    STORE  = 2'd3
  } state_e;

  typedef enum logic {
    CH_PITCH  = 1'b0,
    CH_VOLUME = 1'b1
  } ch_e;

  // The channel that is not ch.
  function automatic ch_e ch_other(input ch_e ch);
    return (ch == CH_PITCH) ? CH_VOLUME : CH_PITCH;
  endfunction

  // Pointer channel wins if it requests, otherwise the other channel.
  // Only meaningful when at least one request is high.
  function automatic ch_e rr_pick(input ch_e ptr, input logic pitch_req,
                                  input logic volume_req);
    logic ptr_req;
    ptr_req = (ptr == CH_PITCH) ? pitch_req : volume_req;
    return ptr_req ? ptr : ch_other(ptr);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   sq_i         : asynchronous square wave
//   rise_o       : one-cycle pulse, 3 cycles after the input rises
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic sq_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sq_i};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meas_scheduler.sv
// Shares one gated edge counter between the pitch and volume oscillator
// inputs. Each measurement is SETTLE_CYCLES of dead time followed by a
// GATE_CYCLES counting window and a one-cycle STORE; grants alternate
// round-robin between the requesting channels.
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : run enable; low during SETTLE/GATE aborts
//   pitch_sq, volume_sq     : asynchronous oscillator square waves
//   pitch_req, volume_req   : per-channel measurement request levels
//   pitch_count/valid/ovf   : last pitch result, new-result pulse, saturated
//   volume_count/valid/ovf  : last volume result, new-result pulse, saturated
//   active_ch               : granted channel (0 pitch, 1 volume)
//   busy                    : FSM is not IDLE
module freq_meas_scheduler
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pitch_sq,
  input  logic             volume_sq,
  input  logic             pitch_req,
  input  logic             volume_req,
  output logic [CNT_W-1:0] pitch_count,
  output logic             pitch_valid,
  output logic             pitch_ovf,
  output logic [CNT_W-1:0] volume_count,
  output logic             volume_valid,
  output logic             volume_ovf,
  output logic             active_ch,
  output logic             busy
);

  localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // Input conditioning
  logic pitch_rise, volume_rise;

  edge_sync u_sync_pitch (
    .clk     (clk),
    .reset_n (reset_n),
    .sq_i    (pitch_sq),
    .rise_o  (pitch_rise)
  );

  edge_sync u_sync_volume (
    .clk     (clk),
    .reset_n (reset_n),
    .sq_i    (volume_sq),
    .rise_o  (volume_rise)
  );

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  ch_e              active_q, active_d;
  ch_e              ptr_q, ptr_d;
  logic             edge_sel_q;
  logic             store_c;
  logic             any_req_c;
  ch_e              grant_c;

  assign any_req_c = pitch_req | volume_req;
  assign grant_c   = rr_pick(ptr_q, pitch_req, volume_req);

  // Selected edge stream; the extra stage is flushed by the settle period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_q <= 1'b0;
    end else begin
      edge_sel_q <= (active_q == CH_VOLUME) ? volume_rise : pitch_rise;
    end
  end

  // Next-state: FSM, window timer, saturating counter, arbitration
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    active_d  = active_q;
    ptr_d     = ptr_q;
    store_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
        if (enable && any_req_c) begin
          state_d  = SETTLE;
          tmr_d    = SETTLE_LOAD;
          active_d = grant_c;
          ptr_d    = ch_other(grant_c);
        end
      end

      SETTLE: begin
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = GATE;
          tmr_d   = GATE_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          if (edge_sel_q) begin
            if (cnt_q == CNT_MAX) begin
              ovf_acc_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (tmr_q == '0) begin
            state_d = STORE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end

      STORE: begin
        store_c = 1'b1;
        if (enable && any_req_c) begin
          state_d  = SETTLE;
          tmr_d    = SETTLE_LOAD;
          active_d = grant_c;
          ptr_d    = ch_other(grant_c);
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      active_q  <= CH_PITCH;
      ptr_q     <= CH_PITCH;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      active_q  <= active_d;
      ptr_q     <= ptr_d;
    end
  end

  // Result registers; only the granted channel is written on STORE.
  logic [CNT_W-1:0] pitch_count_q, volume_count_q;
  logic             pitch_valid_q, volume_valid_q;
  logic             pitch_ovf_q, volume_ovf_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pitch_count_q  <= '0;
      pitch_valid_q  <= 1'b0;
      pitch_ovf_q    <= 1'b0;
      volume_count_q <= '0;
      volume_valid_q <= 1'b0;
      volume_ovf_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      pitch_valid_q  <= 1'b0;
      volume_valid_q <= 1'b0;
      busy_q         <= (state_d != IDLE);
      if (store_c) begin
        if (active_q == CH_PITCH) begin
          pitch_count_q <= cnt_q;
          pitch_ovf_q   <= ovf_acc_q;
          pitch_valid_q <= 1'b1;
        end else begin
          volume_count_q <= cnt_q;
          volume_ovf_q   <= ovf_acc_q;
          volume_valid_q <= 1'b1;
        end
      end
    end
  end

  assign pitch_count  = pitch_count_q;
  assign pitch_valid  = pitch_valid_q;
  assign pitch_ovf    = pitch_ovf_q;
  assign volume_count = volume_count_q;
  assign volume_valid = volume_valid_q;
  assign volume_ovf   = volume_ovf_q;
  assign active_ch    = active_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Scoreboard bench for freq_meas_scheduler: expected results (channel,
// count, ovf, arrival cycle) are queued when a run starts and compared when
// a valid pulse appears.
module tb_freq_meas_scheduler;

  localparam int unsigned G       = 1000;
  localparam int unsigned S       = 2;
  localparam int unsigned CW      = 8;
  localparam int          PER_RES = S + G + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          pitch_sq = 1'b0;
  logic          volume_sq = 1'b0;
  logic          pitch_req = 1'b0;
  logic          volume_req = 1'b0;
  logic [CW-1:0] pitch_count, volume_count;
  logic          pitch_valid, volume_valid, pitch_ovf, volume_ovf;
  logic          active_ch, busy;

  freq_meas_scheduler #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pitch_sq     (pitch_sq),
    .volume_sq    (volume_sq),
    .pitch_req    (pitch_req),
    .volume_req   (volume_req),
    .pitch_count  (pitch_count),
    .pitch_valid  (pitch_valid),
    .pitch_ovf    (pitch_ovf),
    .volume_count (volume_count),
    .volume_valid (volume_valid),
    .volume_ovf   (volume_ovf),
    .active_ch    (active_ch),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ch;
    int   count;
    logic ovf;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pitch_per = 10;
  int   volume_per = 25;
  int   p_ph = 0;
  int   v_ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Square waves in clk-period units, changing on the falling edge
  always @(negedge clk) begin
    pitch_sq  = (p_ph < pitch_per / 2);
    volume_sq = (v_ph < volume_per / 2);
    p_ph = (p_ph + 1 >= pitch_per) ? 0 : p_ph + 1;
    v_ph = (v_ph + 1 >= volume_per) ? 0 : v_ph + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Result monitor
  always @(posedge clk) begin
    exp_t e;
    logic ch;
    #1;
    if (reset_n) begin
      if (pitch_valid && volume_valid) begin
        check_eq("dual_valid", 32'd1, 32'd0);
      end else if (pitch_valid || volume_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_valid", 32'd1, 32'd0);
        end else begin
          e  = sb_q.pop_front();
          ch = volume_valid;
          check_eq("result_ch", 32'(ch), 32'(e.ch));
          check_eq("result_count", ch ? 32'(volume_count) : 32'(pitch_count), 32'(e.count));
          check_eq("result_ovf", ch ? 32'(volume_ovf) : 32'(pitch_ovf), 32'(e.ovf));
          check_eq("result_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    check_eq("rst_pitch_count", 32'(pitch_count), 32'd0);
    check_eq("rst_volume_count", 32'(volume_count), 32'd0);
    check_eq("rst_valids", 32'({pitch_valid, volume_valid}), 32'd0);
    check_eq("rst_ovfs", 32'({pitch_ovf, volume_ovf}), 32'd0);
    check_eq("rst_active_busy", 32'({active_ch, busy}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Raise enable at a falling edge; returns the cycle of the first valid.
  task automatic start_run(output int t0);
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc + 1 + PER_RES;
  endtask

  task automatic push_exp(input logic ch, input int count, input logic ovf, input int at);
    exp_t e;
    e.ch = ch; e.count = count; e.ovf = ovf; e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    @(negedge clk);
    check_eq("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;

    // Pitch only, period 10
    do_reset();
    pitch_per = 10; pitch_req = 1'b1; volume_req = 1'b0;
    start_run(t0);
    for (int i = 0; i < 3; i++) push_exp(1'b0, 100, 1'b0, t0 + i * PER_RES);
    repeat (10) @(negedge clk);
    check_eq("p_only_active", 32'({active_ch, busy}), 32'd1);
    wait_drain(3 * PER_RES + 50);
    stop_run();
    check_eq("p_only_vol_untouched", 32'({volume_count, volume_ovf}), 32'd0);

    // Both requesting, alternating grants
    do_reset();
    pitch_per = 10; volume_per = 25; pitch_req = 1'b1; volume_req = 1'b1;
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    push_exp(1'b1, 40, 1'b0, t0 + PER_RES);
    push_exp(1'b0, 100, 1'b0, t0 + 2 * PER_RES);
    wait_drain(3 * PER_RES + 50);
    stop_run();

    // Saturation, then a clean window clears ovf
    do_reset();
    pitch_per = 2; pitch_req = 1'b1; volume_req = 1'b0;
    start_run(t0);
    push_exp(1'b0, 255, 1'b1, t0);
    wait_drain(PER_RES + 50);
    stop_run();
    check_eq("sat_held_count", 32'(pitch_count), 32'd255);
    check_eq("sat_held_ovf", 32'(pitch_ovf), 32'd1);
    pitch_per = 10;
    repeat (20) @(negedge clk);
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    wait_drain(PER_RES + 50);
    stop_run();

    // Abort mid-gate, then re-enable for a full window
    do_reset();
    pitch_per = 10; pitch_req = 1'b1; volume_req = 1'b0;
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    wait_drain(PER_RES + 50);
    repeat (502) @(negedge clk);
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_count_held", 32'(pitch_count), 32'd100);
    repeat (1100) @(negedge clk);
    check_eq("abort_still_idle", 32'(busy), 32'd0);
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    wait_drain(PER_RES + 50);
    stop_run();

    // volume_req dropped mid volume window
    do_reset();
    pitch_per = 10; volume_per = 25; pitch_req = 1'b1; volume_req = 1'b1;
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    push_exp(1'b1, 40, 1'b0, t0 + PER_RES);
    push_exp(1'b0, 100, 1'b0, t0 + 2 * PER_RES);
    push_exp(1'b0, 100, 1'b0, t0 + 3 * PER_RES);
    for (int i = 0; i < PER_RES + 50 && sb_q.size() > 3; i++) @(negedge clk);
    repeat (500) @(negedge clk);
    check_eq("vdrop_active", 32'(active_ch), 32'd1);
    volume_req = 1'b0;
    wait_drain(4 * PER_RES + 50);
    stop_run();

    // Asynchronous reset mid-gate
    do_reset();
    pitch_per = 10; volume_per = 25; pitch_req = 1'b1; volume_req = 1'b1;
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    wait_drain(PER_RES + 50);
    repeat (300) @(negedge clk);
    check_eq("pre_rst_active", 32'(active_ch), 32'd1);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check_eq("async_rst_pcount", 32'(pitch_count), 32'd0);
    check_eq("async_rst_active", 32'(active_ch), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_run(t0);
    push_exp(1'b0, 100, 1'b0, t0);
    wait_drain(PER_RES + 50);
    stop_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
